output_weight_update: RTL and testbench

//  Backward-pass partner of the output neuron: on a b_pass request it updates the 8 output-layer

---
 rtl/nn_pkg.sv | 18 +
 rtl/wu_mac_sat.sv | 38 +++
 rtl/output_weight_update.sv | 102 ++++++++++
 tb/tb_output_weight_update.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared widths, FSM state and index types
// for the output-layer training datapath.
package nn_pkg;

  localparam int ACT_W    = 10;
  localparam int ERR_W    = 12;
  localparam int WEIGHT_W = 8;
  localparam int N_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  typedef logic [2:0] idx_t;

endpackage

// File: rtl/wu_mac_sat.sv
// One weight step: w - ((err * x) >>> LR_SHIFT),
// clamped to the signed weight range.
module wu_mac_sat #(
  parameter int ACT_W    = 10,
  parameter int ERR_W    = 12,
  parameter int WEIGHT_W = 8,
  parameter int LR_SHIFT = 6
) (
  input  logic signed [ERR_W-1:0]    err_i,
  input  logic        [ACT_W-1:0]    x_i,
  input  logic signed [WEIGHT_W-1:0] w_i,
  output logic signed [WEIGHT_W-1:0] w_o
);

  localparam int PW   = ERR_W + ACT_W + 1;
  localparam int SW   = PW + 1;
  localparam int MAXI = 2**(WEIGHT_W-1) - 1;
  localparam int MINI = -(2**(WEIGHT_W-1));

  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_delta;
  logic signed [SW-1:0] w_sum;

  // x is unsigned, so it gets a zero sign bit
  assign w_prod  = PW'(err_i) * PW'($signed({1'b0, x_i}));
  assign w_delta = w_prod >>> LR_SHIFT;
  assign w_sum   = SW'(w_i) - SW'(w_delta);

  always_comb begin
    w_o = w_sum[WEIGHT_W-1:0];
    if (w_sum > SW'(MAXI)) begin
      w_o = WEIGHT_W'(MAXI);
    end else if (w_sum < SW'(MINI)) begin
      w_o = WEIGHT_W'(MINI);
    end
  end

endmodule

// File: rtl/output_weight_update.sv
// Sequential update of the 8 output-layer weights,
// one weight per cycle, with a done pulse.
module output_weight_update #(
  parameter int ACT_W    = nn_pkg::ACT_W,
  parameter int ERR_W    = nn_pkg::ERR_W,
  parameter int WEIGHT_W = nn_pkg::WEIGHT_W,
  parameter int LR_SHIFT = 6,
  parameter int INIT_W   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    load_i,
  input  logic [8*WEIGHT_W-1:0]   init_w_i,
  input  logic                    start_i,
  input  logic signed [ERR_W-1:0] err_i,
  input  logic [8*ACT_W-1:0]      x_i,
  output logic [8*WEIGHT_W-1:0]   w_o,
  output logic                    busy_o,
  output logic                    done_o
);

  import nn_pkg::*;

  localparam logic [WEIGHT_W-1:0] W_RST = WEIGHT_W'(INIT_W);

  state_t                      r_state;
  state_t                      w_nxt;
  idx_t                        r_idx;
  logic signed [ERR_W-1:0]     r_err;
  logic [8*ACT_W-1:0]          r_x;
  logic [8*WEIGHT_W-1:0]       r_w;
  logic                        r_busy;
  logic                        r_done;
  logic [ACT_W-1:0]            w_xk;
  logic signed [WEIGHT_W-1:0]  w_wk;
  logic signed [WEIGHT_W-1:0]  w_wnew;

  assign w_xk = r_x[int'(r_idx)*ACT_W +: ACT_W];
  assign w_wk = r_w[int'(r_idx)*WEIGHT_W +: WEIGHT_W];

  wu_mac_sat #(
    .ACT_W    (ACT_W),
    .ERR_W    (ERR_W),
    .WEIGHT_W (WEIGHT_W),
    .LR_SHIFT (LR_SHIFT)
  ) u_mac (
    .err_i (r_err),
    .x_i   (w_xk),
    .w_i   (w_wk),
    .w_o   (w_wnew)
  );

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (!load_i && start_i) w_nxt = ST_CALC;
      end
      ST_CALC: begin
        if (r_idx == idx_t'(7)) w_nxt = ST_DONE;
      end
      ST_DONE: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_err   <= '0;
      r_x     <= '0;
      r_w     <= {8{W_RST}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (en_i) begin
      r_state <= w_nxt;
      // outputs lag the state by one edge
      r_busy  <= (r_state != ST_IDLE);
      r_done  <= (r_state == ST_DONE);
      if (r_state == ST_IDLE) begin
        if (load_i) begin
          r_w <= init_w_i;
        end else if (start_i) begin
          r_err <= err_i;
          r_x   <= x_i;
          r_idx <= '0;
        end
      end else if (r_state == ST_CALC) begin
        r_w[int'(r_idx)*WEIGHT_W +: WEIGHT_W] <= w_wnew;
        r_idx <= r_idx + idx_t'(1);
      end
    end
  end

  assign w_o    = r_w;
  assign busy_o = r_busy;
  // a pulse held over a disabled stretch appears once en returns
  assign done_o = r_done & en_i;

endmodule

// File: tb/tb_output_weight_update.sv
// Directed checks of the output weight update block
// against hand-computed weight vectors.
module tb_output_weight_update;

  logic        clk = 1'b0;
  logic        rst, en, load, start;
  logic [63:0] init_w;
  logic [11:0] err;
  logic [79:0] x;
  logic [63:0] w;
  logic        busy, done;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  output_weight_update dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .load_i   (load),
    .init_w_i (init_w),
    .start_i  (start),
    .err_i    (err),
    .x_i      (x),
    .w_o      (w),
    .busy_o   (busy),
    .done_o   (done)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pk(
    input int a0, input int a1, input int a2, input int a3,
    input int a4, input int a5, input int a6, input int a7);
    return {8'(a7), 8'(a6), 8'(a5), 8'(a4),
            8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [79:0] xv(
    input int a0, input int a1, input int a2, input int a3,
    input int a4, input int a5, input int a6, input int a7);
    return {10'(a7), 10'(a6), 10'(a5), 10'(a4),
            10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  task automatic do_load(input logic [63:0] v);
    load = 1'b1;
    init_w = v;
    tick();
    load = 1'b0;
  endtask

  // mode 0 plain, 1 start+load during CALC,
  // 2 en low for 3 edges, 3 reset at index 4
  task automatic run(input logic [11:0] e, input logic [79:0] xi,
                     input int mode, output int lat,
                     output int nd, output int b1);
    lat = -1;
    nd  = 0;
    b1  = 0;
    start = 1'b1;
    err = e;
    x = xi;
    tick();
    start = 1'b0;
    err = '0;
    x = '0;
    for (int i = 1; i <= 25; i++) begin
      if (mode == 1 && i == 3) begin
        start = 1'b1;
        load = 1'b1;
        init_w = '0;
      end
      if (mode == 1 && i == 4) begin
        start = 1'b0;
        load = 1'b0;
      end
      if (mode == 2) en = !(i >= 3 && i <= 5);
      if (mode == 3) rst = (i == 5);
      tick();
      if (i == 1) b1 = int'(busy);
      if (done) begin
        nd++;
        if (lat < 0) lat = i;
      end
    end
    en = 1'b1;
    rst = 1'b0;
  endtask

  int lat, nd, b1, nb;

  initial begin
    rst = 1'b1;
    en = 1'b1;
    load = 1'b0;
    start = 1'b0;
    init_w = '0;
    err = '0;
    x = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_w", w, pk(1,1,1,1,1,1,1,1));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    do_load(pk(10,10,10,10,10,10,10,10));
    check("load10", w, pk(10,10,10,10,10,10,10,10));

    run(12'sd64, xv(1,2,3,4,5,6,7,8), 0, lat, nd, b1);
    check("t2_w", w, pk(9,8,7,6,5,4,3,2));
    check("t2_lat", 64'(lat), 64'd9);
    check("t2_ndone", 64'(nd), 64'd1);
    check("t2_busy1", 64'(b1), 64'd1);
    check("t2_idle", 64'(busy), 64'd0);

    do_load(pk(-120,0,0,0,0,0,0,0));
    run(12'sd2047, xv(1023,0,0,0,0,0,0,0), 0, lat, nd, b1);
    check("t3_satlo", w, pk(-128,0,0,0,0,0,0,0));

    do_load(pk(0,120,0,0,0,0,0,0));
    run(-12'sd2048, xv(0,1023,0,0,0,0,0,0), 0, lat, nd, b1);
    check("t3_sathi", w, pk(0,127,0,0,0,0,0,0));

    do_load(pk(5,5,5,5,5,5,5,5));
    run(-12'sd1, xv(1,1,1,1,1,1,1,1), 0, lat, nd, b1);
    check("t4_floor", w, pk(6,6,6,6,6,6,6,6));
    run(12'sd0, xv(1,1,1,1,1,1,1,1), 0, lat, nd, b1);
    check("t4_err0", w, pk(6,6,6,6,6,6,6,6));
    check("t4_done", 64'(nd), 64'd1);

    do_load(pk(10,10,10,10,10,10,10,10));
    run(12'sd64, xv(1,2,3,4,5,6,7,8), 1, lat, nd, b1);
    check("t5_ignw", w, pk(9,8,7,6,5,4,3,2));
    check("t5_ndone", 64'(nd), 64'd1);
    check("t5_lat", 64'(lat), 64'd9);

    do_load(pk(3,3,3,3,3,3,3,3));
    load = 1'b1;
    start = 1'b1;
    init_w = pk(4,4,4,4,4,4,4,4);
    err = 12'sd64;
    x = xv(1,1,1,1,1,1,1,1);
    tick();
    load = 1'b0;
    start = 1'b0;
    nb = 0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy) nb++;
      if (done) nd++;
    end
    check("t5_loadwin", w, pk(4,4,4,4,4,4,4,4));
    check("t5_nobusy", 64'(nb), 64'd0);
    check("t5_nodone", 64'(nd), 64'd0);

    do_load(pk(10,10,10,10,10,10,10,10));
    run(12'sd64, xv(1,2,3,4,5,6,7,8), 3, lat, nd, b1);
    check("t6_rstw", w, pk(1,1,1,1,1,1,1,1));
    check("t6_rstdone", 64'(nd), 64'd0);
    check("t6_rstbusy", 64'(busy), 64'd0);

    do_load(pk(10,10,10,10,10,10,10,10));
    run(12'sd64, xv(1,2,3,4,5,6,7,8), 2, lat, nd, b1);
    check("t6_enw", w, pk(9,8,7,6,5,4,3,2));
    check("t6_enlat", 64'(lat), 64'd12);
    check("t6_endone", 64'(nd), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
